pu_weight_stream_decoder: RTL and testbench

- Parametrised successor to the PU unique-weight buffer.
- Fetches packed SRAM words through a request/acknowledge handshake and keeps a multi-word shift buffer.
- Splits the bit stream into variable-length weight tokens: absolute tokens of BIN_LEN bits, or delta tokens of a run-time delta length.
- Delivers tokens to the PU datapath over a valid/ready handshake, prefetching during consumption, and ends itself after a programmed token count.

---
 rtl/pu_weight_stream_decoder.sv | 152 +++++++++++++++
 tb/tb_pu_weight_stream_decoder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_weight_stream_decoder.sv
// Weight stream decoder: fetches packed SRAM words into a multi-word shift buffer
// and splits the bit stream into absolute / delta weight tokens for the PU datapath.
module pu_weight_stream_decoder #(
    parameter int unsigned SRAM_LEN      = 64,
    parameter int unsigned BIN_LEN       = 8,
    parameter int unsigned MAX_DELTA_LEN = 8,
    parameter int unsigned BUF_WORDS     = 3,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned CNT_W         = 24
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [CNT_W-1:0]               token_count,
    input  logic [$clog2(MAX_DELTA_LEN):0] delta_len,
    output logic                           word_req,
    output logic [ADDR_W-1:0]              word_addr,
    input  logic                           word_ack,
    input  logic [SRAM_LEN-1:0]            word_data,
    output logic                           weight_valid,
    input  logic                           weight_ready,
    output logic [BIN_LEN-1:0]             weight_val,
    output logic                           weight_abs,
    output logic [CNT_W-1:0]               tokens_left,
    output logic [ADDR_W-1:0]              words_fetched,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_error
);
    localparam int unsigned CAP    = BUF_WORDS * SRAM_LEN;
    localparam int unsigned FILL_W = $clog2(CAP) + 1;
    localparam int unsigned DL_W   = $clog2(MAX_DELTA_LEN) + 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t              state;
    logic [CAP-1:0]      buf_q;
    logic [FILL_W-1:0]   fill;
    logic [ADDR_W-1:0]   base_q;
    logic [DL_W-1:0]     dlen_q;

    logic [FILL_W-1:0]   tok_len;
    logic [FILL_W-1:0]   fill_pop;
    logic [FILL_W-1:0]   fill_next;
    logic [CAP-1:0]      buf_pop;
    logic [CAP-1:0]      buf_next;
    logic [BIN_LEN-1:0]  delta_mask;
    logic                fetching;
    logic                pop;
    logic                ack_take;
    logic                can_req;
    logic                cfg_ok;

    // Head decode: bit 0 selects absolute (BIN_LEN) or delta (dlen_q) token
    always_comb begin
        tok_len    = buf_q[0] ? FILL_W'(BIN_LEN) : FILL_W'(dlen_q);
        delta_mask = ~({BIN_LEN{1'b1}} << dlen_q);
        weight_abs = buf_q[0];
        weight_val = buf_q[0] ? buf_q[BIN_LEN-1:0] : (buf_q[BIN_LEN-1:0] & delta_mask);
    end

    assign fetching     = (state == FILL) || (state == STREAM);
    assign weight_valid = (state == STREAM) && (fill >= tok_len);
    assign pop          = weight_valid && weight_ready;
    assign ack_take     = fetching && word_req && word_ack;
    assign can_req      = fetching && !word_req && (tokens_left != '0) &&
                          ((FILL_W'(CAP) - fill) >= FILL_W'(SRAM_LEN));
    assign cfg_ok       = (delta_len != '0) && (delta_len <= DL_W'(MAX_DELTA_LEN)) &&
                          (token_count != '0);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    // Pop first, then append the acked word just above the surviving bits
    always_comb begin
        buf_pop   = pop ? (buf_q >> tok_len) : buf_q;
        fill_pop  = pop ? (fill - tok_len) : fill;
        buf_next  = buf_pop;
        fill_next = fill_pop;
        if (ack_take) begin
            buf_next  = buf_pop | (CAP'(word_data) << fill_pop);
            fill_next = fill_pop + FILL_W'(SRAM_LEN);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            buf_q         <= '0;
            fill          <= '0;
            base_q        <= '0;
            dlen_q        <= '0;
            word_req      <= 1'b0;
            word_addr     <= '0;
            tokens_left   <= '0;
            words_fetched <= '0;
            cfg_error     <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            buf_q    <= '0;
            fill     <= '0;
            word_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            base_q        <= base_addr;
                            dlen_q        <= delta_len;
                            tokens_left   <= token_count;
                            words_fetched <= '0;
                            buf_q         <= '0;
                            fill          <= '0;
                            cfg_error     <= 1'b0;
                            state         <= FILL;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                FILL, STREAM: begin
                    buf_q <= buf_next;
                    fill  <= fill_next;
                    // Single outstanding request; address frozen until acked
                    if (ack_take) begin
                        word_req      <= 1'b0;
                        words_fetched <= words_fetched + ADDR_W'(1);
                    end else if (can_req) begin
                        word_req  <= 1'b1;
                        word_addr <= base_q + words_fetched;
                    end
                    if (pop) begin
                        tokens_left <= tokens_left - CNT_W'(1);
                        if (tokens_left == CNT_W'(1)) begin
                            state    <= DONE;
                            word_req <= 1'b0;
                        end
                    end
                    if ((state == FILL) && (fill >= FILL_W'(BIN_LEN))) begin
                        state <= STREAM;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    word_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pu_weight_stream_decoder.sv
// Bench for pu_weight_stream_decoder: bit-queue reference model plus a config
// vector table and directed sequences for stall, latency, abort and reset cases.
module tb_pu_weight_stream_decoder;
    localparam int unsigned SRAM_LEN      = 16;
    localparam int unsigned BIN_LEN       = 8;
    localparam int unsigned MAX_DELTA_LEN = 8;
    localparam int unsigned BUF_WORDS     = 3;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned CNT_W         = 24;
    localparam int unsigned CAP           = BUF_WORDS * SRAM_LEN;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                start;
    logic                abort;
    logic [ADDR_W-1:0]   base_addr;
    logic [CNT_W-1:0]    token_count;
    logic [3:0]          delta_len;
    logic                word_req;
    logic [ADDR_W-1:0]   word_addr;
    logic                word_ack;
    logic [SRAM_LEN-1:0] word_data;
    logic                weight_valid;
    logic                weight_ready;
    logic [BIN_LEN-1:0]  weight_val;
    logic                weight_abs;
    logic [CNT_W-1:0]    tokens_left;
    logic [ADDR_W-1:0]   words_fetched;
    logic                busy;
    logic                done;
    logic                cfg_error;

    pu_weight_stream_decoder #(
        .SRAM_LEN(SRAM_LEN), .BIN_LEN(BIN_LEN), .MAX_DELTA_LEN(MAX_DELTA_LEN),
        .BUF_WORDS(BUF_WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .token_count(token_count), .delta_len(delta_len),
        .word_req(word_req), .word_addr(word_addr), .word_ack(word_ack),
        .word_data(word_data), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .weight_val(weight_val), .weight_abs(weight_abs), .tokens_left(tokens_left),
        .words_fetched(words_fetched), .busy(busy), .done(done), .cfg_error(cfg_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  dl;
        logic [23:0] tc;
        logic        exp_err;
        logic        exp_busy;
    } cfg_vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs
    int          ack_lat   = 0;
    int          ready_pct = 100;
    int          stall_tok = -1;
    int          stall_cyc = 0;
    logic [15:0] data_mask = 16'hFFFF;
    logic [15:0] dir_words[$];
    logic        stray_ack = 1'b0;

    // Reference model: the undecoded stream as a queue of bits, LSB first
    bit          mq[$];
    int          exp_left, exp_words, exp_dlen;
    logic [31:0] exp_base;
    logic [7:0]  got_val[$];
    bit          got_abs[$];
    int          run_len, max_run, max_fill, wait_cnt, stall_cnt;
    bit          prev_hold, prev_stall, prev_abs;
    logic [31:0] prev_addr;
    logic [7:0]  prev_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int head_len();
        if (mq.size() > 0 && mq[0]) return BIN_LEN;
        return exp_dlen;
    endfunction

    function automatic logic [7:0] head_val(input int len);
        logic [7:0] v = '0;
        for (int i = 0; i < len; i++) v[i] = mq[i];
        return v;
    endfunction

    task automatic model_loop();
        int len;
        bit pop;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mq.delete();
                word_ack = 1'b0; weight_ready = 1'b0;
                wait_cnt = 0; prev_hold = 0; prev_stall = 0; run_len = 0;
                continue;
            end
            // Observe the state settled after the last rising edge
            if (prev_hold) begin
                chk("req_hold", word_req, 1);
                chk("addr_hold", word_addr, prev_addr);
            end
            if (prev_stall) begin
                chk("stall_valid", weight_valid, 1);
                chk("stall_tok", {weight_abs, weight_val}, {prev_abs, prev_val});
            end
            if (weight_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                len = head_len();
                chk("bits_avail", mq.size() >= len, 1);
                if (mq.size() >= len)
                    chk("token", {weight_abs, weight_val}, {mq[0], head_val(len)});
            end else begin
                run_len = 0;
            end
            if (busy && !done) begin
                chk("tokens_left", tokens_left, exp_left);
                chk("words_fetched", words_fetched, exp_words);
            end
            if (word_req) chk("word_addr", word_addr, exp_base + 32'(exp_words));

            // Drive consumer and memory for the next edge
            if (stall_tok >= 0 && got_val.size() == stall_tok && stall_cnt < stall_cyc) begin
                weight_ready = 1'b0;
                if (weight_valid) stall_cnt++;
            end else begin
                weight_ready = ($urandom_range(99) < ready_pct);
            end
            word_ack = 1'b0;
            if (word_req) begin
                if (wait_cnt >= ack_lat) begin
                    word_ack  = 1'b1;
                    word_data = (exp_words < dir_words.size()) ? dir_words[exp_words]
                                                               : (16'($urandom) & data_mask);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            if (stray_ack) begin
                word_ack  = 1'b1;
                word_data = 16'hFFFF;
            end

            // Predict the effect of the coming edge
            prev_hold  = 0;
            prev_stall = 0;
            if (abort) begin
                mq.delete();
            end else if (start && delta_len >= 1 && delta_len <= 4'(MAX_DELTA_LEN) && token_count != 0) begin
                mq.delete(); got_val.delete(); got_abs.delete();
                exp_left = int'(token_count); exp_words = 0; exp_dlen = int'(delta_len);
                exp_base = base_addr; max_run = 0; max_fill = 0; run_len = 0; stall_cnt = 0;
            end else begin
                pop = weight_valid && weight_ready;
                if (pop) begin
                    len = head_len();
                    got_val.push_back(head_val(len));
                    got_abs.push_back(mq.size() > 0 ? mq[0] : 1'b0);
                    repeat (len) if (mq.size() > 0) void'(mq.pop_front());
                    exp_left--;
                end
                if (word_req && word_ack) begin
                    for (int i = 0; i < SRAM_LEN; i++) mq.push_back(word_data[i]);
                    exp_words++;
                    if (mq.size() > max_fill) max_fill = mq.size();
                    chk("fill_cap", mq.size() <= CAP, 1);
                end
                prev_hold  = word_req && !word_ack && !(pop && exp_left == 0);
                prev_addr  = word_addr;
                prev_stall = weight_valid && !weight_ready;
                prev_val   = weight_val;
                prev_abs   = weight_abs;
            end
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_req"}, word_req, 0);
        chk({name, "_addr"}, word_addr, 0);
        chk({name, "_valid"}, weight_valid, 0);
        chk({name, "_val"}, weight_val, 0);
        chk({name, "_abs"}, weight_abs, 0);
        chk({name, "_left"}, tokens_left, 0);
        chk({name, "_words"}, words_fetched, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_err"}, cfg_error, 0);
    endtask

    task automatic do_start(input logic [31:0] b, input int dl, input int tc);
        @(posedge clock); #1;
        base_addr = b; delta_len = 4'(dl); token_count = 24'(tc); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clock); #1;
            if (done) seen = 1;
        end
        chk({name, "_done_seen"}, seen, 1);
        @(posedge clock); #1;
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        cfg_vec_t    cv[7];
        logic [8:0]  exp_tok[3];
        bit          seen;
        int          tc;

        cv[0] = '{dl: 4'd0,  tc: 24'd5, exp_err: 1'b1, exp_busy: 1'b0};
        cv[1] = '{dl: 4'd4,  tc: 24'd3, exp_err: 1'b0, exp_busy: 1'b1};
        cv[2] = '{dl: 4'd9,  tc: 24'd5, exp_err: 1'b1, exp_busy: 1'b0};
        cv[3] = '{dl: 4'd4,  tc: 24'd0, exp_err: 1'b1, exp_busy: 1'b0};
        cv[4] = '{dl: 4'd8,  tc: 24'd2, exp_err: 1'b0, exp_busy: 1'b1};
        cv[5] = '{dl: 4'd15, tc: 24'd7, exp_err: 1'b1, exp_busy: 1'b0};
        cv[6] = '{dl: 4'd1,  tc: 24'd1, exp_err: 1'b0, exp_busy: 1'b1};
        exp_tok[0] = 9'h1A5; exp_tok[1] = 9'h002; exp_tok[2] = 9'h006;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; token_count = '0; delta_len = '0;
        word_ack = 1'b0; word_data = '0; weight_ready = 1'b0;
        fork model_loop(); join_none

        repeat (3) @(posedge clock);
        #1;
        check_zero("rst");
        reset_n = 1'b1;

        // Single word 62A5: one absolute then two 4-bit delta tokens
        ack_lat = 10; ready_pct = 100; dir_words = '{16'h62A5};
        do_start(32'h100, 4, 3);
        wait_done(200, "t1");
        chk("t1_count", got_val.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < got_val.size()) chk("t1_tok", {got_abs[i], got_val[i]}, exp_tok[i]);
        chk("t1_left", tokens_left, 0);
        chk("t1_words", words_fetched, 1);

        // Consumer stall on the second token with prefetch running
        ack_lat = 0; stall_tok = 1; stall_cyc = 5;
        do_start(32'h200, 4, 3);
        wait_done(200, "t2");
        chk("t2_stalled", stall_cnt, 5);
        chk("t2_count", got_val.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < got_val.size()) chk("t2_tok", {got_abs[i], got_val[i]}, exp_tok[i]);
        stall_tok = -1; dir_words.delete();

        // Slow memory: request and address must hold for every delayed ack
        ack_lat = 10; ready_pct = 70;
        do_start(32'h1000, 5, 20);
        wait_done(3000, "t3");
        chk("t3_count", got_val.size(), 20);

        // Zero-bubble: 40 delta tokens at full rate with acks overlapping pops
        ack_lat = 0; ready_pct = 100; data_mask = 16'hEEEE;
        do_start(32'h40, 4, 40);
        wait_done(500, "t4");
        chk("t4_count", got_val.size(), 40);
        chk("t4_run", max_run, 40);
        chk("t4_fill", max_fill <= CAP, 1);
        data_mask = 16'hFFFF;

        // Config legality table
        for (int i = 0; i < 7; i++) begin
            do_start(32'h300, int'(cv[i].dl), int'(cv[i].tc));
            chk("cfg_err", cfg_error, cv[i].exp_err);
            chk("cfg_busy", busy, cv[i].exp_busy);
            if (cv[i].exp_busy) begin
                abort = 1'b1;
                @(posedge clock); #1;
                abort = 1'b0;
                chk("cfg_abort_idle", busy, 0);
            end else begin
                repeat (2) @(posedge clock);
                #1;
                chk("cfg_no_req", word_req, 0);
            end
        end

        // Abort while a request is outstanding, then a stray ack in IDLE
        ack_lat = 30; ready_pct = 100;
        do_start(32'h500, 3, 30);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clock); #1;
            if (word_req && words_fetched == 1) seen = 1;
        end
        chk("t6_reach", seen, 1);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_req", word_req, 0);
        chk("t6_valid", weight_valid, 0);
        stray_ack = 1'b1;
        @(posedge clock); #1;
        stray_ack = 1'b0;
        @(posedge clock); #1;
        chk("t6_late_words", words_fetched, 1);
        chk("t6_late_busy", busy, 0);
        chk("t6_late_valid", weight_valid, 0);

        // Randomised runs, including underflow from slow fetch vs fast consumer
        for (int r = 0; r < 6; r++) begin
            ack_lat = $urandom_range(4);
            ready_pct = $urandom_range(100, 40);
            tc = $urandom_range(40, 5);
            do_start(32'($urandom), $urandom_range(8, 1), tc);
            wait_done(4000, "rnd");
            chk("rnd_count", got_val.size(), tc);
        end

        // Reset in the middle of a run
        ack_lat = 2; ready_pct = 60;
        do_start(32'h700, 4, 30);
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        check_zero("midrst");
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
